// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU command sequencer: op encodings, FSM states
// and default datapath widths.
package alu_ctrl_pkg;

  localparam int DATA_W_DEF = 5;
  localparam int RES_W_DEF  = 10;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_A  = 3'd1,
    ST_LOAD_B  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_RESP    = 3'd5
  } state_t;

endpackage

// File: rtl/alu_seq_ctrl.sv
// Command sequencer for the shared-bus ALU: serialises both operands, fires the
// execute strobe, captures the result and returns it on a valid/ready channel.
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RES_W  = RES_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic              rsp_err,
  output logic              alu_load_a,
  output logic              alu_load_b,
  output logic [DATA_W-1:0] alu_data_in,
  output logic [1:0]        alu_op_sel,
  output logic              alu_enable_out,
  input  logic [RES_W-1:0]  alu_result,
  output logic [CNT_W-1:0]  op_count
);

  state_t            state;
  state_t            state_nxt;
  logic              run;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              cmd_fire;
  logic              rsp_fire;

  // run keeps cmd_ready low until the first edge after reset release
  assign cmd_ready = run && (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;

  assign alu_load_a     = (state == ST_LOAD_A);
  assign alu_load_b     = (state == ST_LOAD_B);
  assign alu_enable_out = (state == ST_EXEC);
  assign alu_op_sel     = op_q;
  assign alu_data_in    = (state == ST_LOAD_A) ? a_q :
                          (state == ST_LOAD_B) ? b_q : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (cmd_fire) state_nxt = (cmd_op == OP_ILL) ? ST_RESP : ST_LOAD_A;
      ST_LOAD_A:  state_nxt = ST_LOAD_B;
      ST_LOAD_B:  state_nxt = ST_EXEC;
      ST_EXEC:    state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_RESP;
      ST_RESP:    if (rsp_fire) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      run        <= 1'b0;
      op_q       <= OP_ADD;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      op_count   <= '0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
      if (cmd_fire) begin
        op_q <= cmd_op;
        if (cmd_op == OP_ILL) begin
          rsp_result <= '0;
          rsp_err    <= 1'b1;
        end
      end
      // ALU op_sel is still held here, so the combinational upper bits are valid
      if (state == ST_CAPTURE) begin
        rsp_result <= alu_result;
        rsp_err    <= 1'b0;
      end
      if (rsp_fire) op_count <= op_count + CNT_W'(1);
    end
  end

  // Operand latches need no reset: they are always written before use
  always_ff @(posedge clk) begin
    if (cmd_fire) begin
      a_q <= cmd_a;
      b_q <= cmd_b;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl driving a behavioural model of the
// shared-bus ALU (registered low result bits, combinational upper bits).
module tb_alu_seq_ctrl;
  import alu_ctrl_pkg::*;

  localparam int DW = 5;
  localparam int RW = 10;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [DW-1:0] cmd_a;
  logic [DW-1:0] cmd_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [RW-1:0] rsp_result;
  logic          rsp_err;
  logic          alu_load_a;
  logic          alu_load_b;
  logic [DW-1:0] alu_data_in;
  logic [1:0]    alu_op_sel;
  logic          alu_enable_out;
  logic [RW-1:0] alu_result;
  logic [CW-1:0] op_count;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.DATA_W(DW), .RES_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .alu_load_a(alu_load_a), .alu_load_b(alu_load_b),
    .alu_data_in(alu_data_in), .alu_op_sel(alu_op_sel),
    .alu_enable_out(alu_enable_out), .alu_result(alu_result),
    .op_count(op_count)
  );

  // ALU block model
  logic [DW-1:0] ra, rb, out_lo;
  logic [RW-1:0] alu_comb;

  function automatic logic [RW-1:0] alu_f(input logic [1:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    logic [DW-1:0] s;
    case (op)
      2'b00:   begin s = a + b; return {5'b0, s}; end
      2'b01:   begin s = a - b; return {5'b0, s}; end
      2'b10:   return RW'(a) * RW'(b);
      default: return '0;
    endcase
  endfunction

  assign alu_comb   = alu_f(alu_op_sel, ra, rb);
  assign alu_result = {alu_comb[9:5], out_lo};

  always @(posedge clk) begin
    if (alu_load_a) ra <= alu_data_in;
    if (alu_load_b) rb <= alu_data_in;
    if (alu_enable_out) out_lo <= alu_comb[4:0];
  end

  typedef struct {
    logic [RW-1:0] res;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic flag(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", nm, $time);
  endtask

  // Monitor: every RESP cycle is compared against the scoreboard head
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_cnt = 0;
    end else if (rsp_valid) begin
      chk("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got result %0d, required no response", rsp_result);
      end else begin
        chk("rsp_result", 32'(rsp_result), 32'(sb[0].res));
        chk("rsp_err", 32'(rsp_err), 32'(sb[0].err));
        if (rsp_ready) begin
          chk("op_count_at_hs", 32'(op_count), 32'(exp_cnt));
          void'(sb.pop_front());
          exp_cnt++;
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [RW-1:0] res, input logic err);
    int t = 0;
    while (!cmd_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!cmd_ready) begin
      flag("cmd_ready_wait");
      return;
    end
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    @(posedge clk);
    sb.push_back('{res: res, err: err});
    #1;
    cmd_valid = 1'b0;
    cmd_a = ~a;
    cmd_b = ~b;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb.size() != 0) flag("response_wait");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_alu_strobes", 32'({alu_load_a, alu_load_b, alu_enable_out}), 32'd0);
    chk("rst_alu_bus", 32'({alu_data_in, alu_op_sel}), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("cmd_ready_at_release", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    chk("cmd_ready_after_release", 32'(cmd_ready), 32'd1);

    // add 7+9 with cycle-by-cycle strobe checks
    send(OP_ADD, 5'd7, 5'd9, 10'd16, 1'b0);
    chk("add_load_a", 32'(alu_load_a), 32'd1);
    chk("add_data_a", 32'(alu_data_in), 32'd7);
    chk("add_load_b_idle", 32'(alu_load_b), 32'd0);
    chk("busy_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    chk("add_load_b", 32'({alu_load_a, alu_load_b}), 32'd1);
    chk("add_data_b", 32'(alu_data_in), 32'd9);
    @(posedge clk); #1;
    chk("add_enable", 32'({alu_load_b, alu_enable_out}), 32'd1);
    chk("add_op_sel", 32'(alu_op_sel), 32'(OP_ADD));
    chk("add_bus_idle", 32'(alu_data_in), 32'd0);
    @(posedge clk); #1;
    chk("capture_quiet", 32'({alu_enable_out, rsp_valid}), 32'd0);
    @(posedge clk); #1;
    chk("latency_4", 32'(rsp_valid), 32'd1);
    drain();
    chk("op_count_1", 32'(op_count), 32'd1);

    send(OP_ADD, 5'd20, 5'd15, 10'd3, 1'b0);
    drain();
    send(OP_SUB, 5'd5, 5'd9, 10'd28, 1'b0);
    drain();
    send(OP_MUL, 5'd31, 5'd31, 10'd961, 1'b0);
    drain();
    send(OP_MUL, 5'd0, 5'd17, 10'd0, 1'b0);
    drain();

    // illegal op: response one edge after accept, ALU untouched
    send(OP_ILL, 5'd4, 5'd4, 10'd0, 1'b1);
    chk("ill_latency_1", 32'(rsp_valid), 32'd1);
    chk("ill_no_strobes", 32'({alu_load_a, alu_load_b, alu_enable_out}), 32'd0);
    chk("ill_bus_idle", 32'(alu_data_in), 32'd0);
    drain();
    chk("op_count_6", 32'(op_count), 32'd6);

    // backpressure with a second command waiting
    rsp_ready = 1'b0;
    send(OP_ADD, 5'd3, 5'd4, 10'd7, 1'b0);
    cmd_op = OP_MUL; cmd_a = 5'd6; cmd_b = 5'd5; cmd_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_ready", 32'(cmd_ready), 32'd1);
    chk("bp_rsp_done", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    sb.push_back('{res: 10'd30, err: 1'b0});
    #1;
    cmd_valid = 1'b0;
    chk("bp_second_load_a", 32'(alu_load_a), 32'd1);
    chk("bp_second_data", 32'(alu_data_in), 32'd6);
    drain();
    chk("op_count_8", 32'(op_count), 32'd8);

    // asynchronous reset during LOAD_B of a mul
    send(OP_MUL, 5'd31, 5'd2, 10'd62, 1'b0);
    @(posedge clk); #1;
    chk("pre_rst_load_b", 32'(alu_load_b), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_strobes", 32'({alu_load_a, alu_load_b, alu_enable_out}), 32'd0);
    chk("async_rst_bus", 32'({alu_data_in, alu_op_sel}), 32'd0);
    chk("async_rst_rsp", 32'({rsp_valid, rsp_err, cmd_ready}), 32'd0);
    chk("async_rst_result", 32'(rsp_result), 32'd0);
    chk("async_rst_count", 32'(op_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
    send(OP_ADD, 5'd1, 5'd1, 10'd2, 1'b0);
    drain();
    chk("op_count_after_rst", 32'(op_count), 32'd1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
